// File: rtl/cpu_types_pkg.sv
// Shared types for the coherence bus controller, caches and the RAM port.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  localparam int unsigned RAM_LAT_DEFAULT   = 2;
  localparam int unsigned RAM_DEPTH_DEFAULT = 4096;

endpackage

// File: rtl/mem_latency_counter.sv
// Tracks the request currently being served and counts its BUSY cycles.
module mem_latency_counter
  import cpu_types_pkg::*;
#(
  parameter int unsigned LAT = RAM_LAT_DEFAULT
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  ren_i,
  input  logic  wen_i,
  input  word_t addr_i,
  input  logic  abort_i,
  output logic  eff_done_o
);

  localparam int unsigned CW = (LAT < 1) ? 1 : $clog2(LAT + 1);

  logic          valid_q, valid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  word_t         cap_addr_q, cap_addr_d;
  logic          cap_ren_q, cap_ren_d;
  logic          cap_wen_q, cap_wen_d;
  logic          req;
  logic          match;
  logic [CW-1:0] eff;

  always_comb begin
    req        = ren_i | wen_i;
    match      = valid_q && req && (addr_i == cap_addr_q) &&
                 (ren_i == cap_ren_q) && (wen_i == cap_wen_q);
    eff        = match ? cnt_q : '0;
    eff_done_o = (eff == CW'(LAT));

    valid_d    = valid_q;
    cnt_d      = cnt_q;
    cap_addr_d = cap_addr_q;
    cap_ren_d  = cap_ren_q;
    cap_wen_d  = cap_wen_q;

    // A completed, errored or vanished request always forgets its capture,
    // so a still-held request becomes a fresh access.
    if (!req || abort_i || eff_done_o) begin
      valid_d = 1'b0;
      cnt_d   = '0;
    end else if (!match) begin
      valid_d    = 1'b1;
      cnt_d      = CW'(1);
      cap_addr_d = addr_i;
      cap_ren_d  = ren_i;
      cap_wen_d  = wen_i;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      cnt_q      <= '0;
      cap_addr_q <= '0;
      cap_ren_q  <= 1'b0;
      cap_wen_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      cap_addr_q <= cap_addr_d;
      cap_ren_q  <= cap_ren_d;
      cap_wen_q  <= cap_wen_d;
    end
  end

endmodule

// File: rtl/memory_responder.sv
// Latency-programmable single-word RAM responder for the shared RAM port.
// Optional RAM_ERROR_CHECK_EN: report ERROR on REN&WEN or out-of-range index.
module memory_responder
  import cpu_types_pkg::*;
#(
  parameter int unsigned LAT   = RAM_LAT_DEFAULT,
  parameter int unsigned DEPTH = RAM_DEPTH_DEFAULT
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      ramREN,
  input  logic      ramWEN,
  input  word_t     ramaddr,
  input  word_t     ramstore,
  output word_t     ramload,
  output ramstate_t ramstate
);

  localparam int unsigned AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

  word_t         mem [DEPTH];
  logic [AW-1:0] widx;
  logic          req;
  logic          err;
  logic          eff_done;

  assign widx = ramaddr[AW+1:2];
  assign req  = ramREN | ramWEN;

`ifdef RAM_ERROR_CHECK_EN
  assign err = req && ((ramREN && ramWEN) ||
                       ({2'b00, ramaddr[31:2]} >= 32'(DEPTH)));
`else
  assign err = 1'b0;
`endif

  mem_latency_counter #(
    .LAT(LAT)
  ) u_counter (
    .clk_i      (CLK),
    .rst_i      (RST),
    .ren_i      (ramREN),
    .wen_i      (ramWEN),
    .addr_i     (ramaddr),
    .abort_i    (err),
    .eff_done_o (eff_done)
  );

  always_comb begin
    ramstate = FREE;
    ramload  = '0;
    if (!RST && req) begin
      if (err)           ramstate = ERROR;
      else if (eff_done) ramstate = ACCESS;
      else               ramstate = BUSY;
    end
    // With both strobes high the write wins, so nothing is returned.
    if (ramstate == ACCESS && ramREN && !ramWEN) ramload = mem[widx];
  end

  always_ff @(posedge CLK) begin
    if (ramstate == ACCESS && ramWEN) mem[widx] <= ramstore;
  end

endmodule

// File: tb/tb_memory_responder.sv
// Bench: three responders (LAT 2, 3, 0) on one shared request stream.
module tb_memory_responder;

  localparam int unsigned DEP = 1024;
  localparam logic [1:0] S_FREE = 2'd0, S_BUSY = 2'd1, S_ACC = 2'd2, S_ERR = 2'd3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ren = 1'b0, wen = 1'b0;
  logic [31:0] addr = '0, data = '0;
  logic [31:0] ld0, ld1, ld2;
  logic [1:0]  st0, st1, st2;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  memory_responder #(.LAT(2), .DEPTH(DEP)) u_lat2 (
    .CLK(CLK), .RST(RST), .ramREN(ren), .ramWEN(wen), .ramaddr(addr),
    .ramstore(data), .ramload(ld0), .ramstate(st0));
  memory_responder #(.LAT(3), .DEPTH(DEP)) u_lat3 (
    .CLK(CLK), .RST(RST), .ramREN(ren), .ramWEN(wen), .ramaddr(addr),
    .ramstore(data), .ramload(ld1), .ramstate(st1));
  memory_responder #(.LAT(0), .DEPTH(DEP)) u_lat0 (
    .CLK(CLK), .RST(RST), .ramREN(ren), .ramWEN(wen), .ramaddr(addr),
    .ramstore(data), .ramload(ld2), .ramstate(st2));

  function automatic int lat_of(input int i);
    case (i)
      0:       return 2;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: a request must be held unchanged for LAT cycles after it
  // (re)starts, and is served on the next one; service ends the request.
  logic [31:0] mref  [3][DEP];
  bit          known [3][DEP];
  int          held  [3];
  logic [33:0] prev  [3];

  always @(negedge CLK) begin
    logic [1:0]  es;
    logic [31:0] el, act_ld;
    logic [1:0]  act_st;
    int unsigned wi;
    bit          req, err, ldok;
    for (int i = 0; i < 3; i++) begin
      req = ren | wen;
      wi  = int'(addr[31:2]) % DEP;
`ifdef RAM_ERROR_CHECK_EN
      err = (ren && wen) || (addr[31:2] >= DEP);
`else
      err = 1'b0;
`endif
      if (RST || !req) begin
        es = S_FREE; held[i] = 0;
      end else if (err) begin
        es = S_ERR; held[i] = 0;
      end else begin
        if ({ren, wen, addr} != prev[i]) held[i] = 0;
        es = (held[i] == lat_of(i)) ? S_ACC : S_BUSY;
      end
      prev[i] = {ren, wen, addr};
      el = '0; ldok = 1'b1;
      if (es == S_ACC && ren && !wen) begin
        el = mref[i][wi]; ldok = known[i][wi];
      end
      case (i)
        0:       begin act_st = st0; act_ld = ld0; end
        1:       begin act_st = st1; act_ld = ld1; end
        default: begin act_st = st2; act_ld = ld2; end
      endcase
      check($sformatf("model_state_lat%0d", lat_of(i)), {30'd0, act_st}, {30'd0, es});
      if (ldok) check($sformatf("model_load_lat%0d", lat_of(i)), act_ld, el);
      if (es == S_ACC) begin
        held[i] = 0;
        if (wen) begin mref[i][wi] = data; known[i][wi] = 1'b1; end
      end else if (es == S_BUSY) begin
        held[i]++;
      end
    end
  end

  task automatic apply(input logic r_st, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    @(posedge CLK); #1;
    RST = r_st; ren = r; wen = w; addr = a; data = d;
    @(negedge CLK); #1;
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    int r;
    logic [1:0] s;
    apply(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check("reset_state", {30'd0, st0}, {30'd0, S_FREE});
    check("reset_load", ld0, 32'h0);
    apply(1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
    check("reset_held_req_state", {30'd0, st0}, {30'd0, S_FREE});
    idle();

    for (int c = 0; c < 3; c++) begin
      apply(1'b0, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF);
      s = (c == 2) ? S_ACC : S_BUSY;
      check("t1_write_state", {30'd0, st0}, {30'd0, s});
    end
    for (int c = 0; c < 3; c++) begin
      apply(1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
      s = (c == 2) ? S_ACC : S_BUSY;
      check("t1_read_state", {30'd0, st0}, {30'd0, s});
    end
    check("t1_read_data", ld0, 32'hDEADBEEF);

    for (int c = 0; c < 6; c++) begin
      apply(1'b0, 1'b0, 1'b1, (c < 3) ? 32'h200 : 32'h204, (c < 3) ? 32'h11 : 32'h22);
      s = (c == 2 || c == 5) ? S_ACC : S_BUSY;
      check("t2_burst_state", {30'd0, st0}, {30'd0, s});
    end
    idle();
    for (int c = 0; c < 6; c++) begin
      apply(1'b0, 1'b1, 1'b0, (c < 3) ? 32'h200 : 32'h204, 32'h0);
      if (c == 2) check("t2_read_lo", ld0, 32'h11);
      if (c == 5) check("t2_read_hi", ld0, 32'h22);
    end

    idle();
    for (int c = 0; c < 4; c++) apply(1'b0, 1'b0, 1'b1, 32'h80, 32'h12345678);
    check("t3_prefill_state", {30'd0, st1}, {30'd0, S_ACC});
    idle();
    for (int c = 0; c < 5; c++) begin
      apply(1'b0, 1'b1, 1'b0, (c == 0) ? 32'h40 : 32'h80, 32'h0);
      s = (c == 4) ? S_ACC : S_BUSY;
      check("t3_switch_state", {30'd0, st1}, {30'd0, s});
    end
    check("t3_switch_data", ld1, 32'h12345678);

    idle();
    for (int c = 0; c < 2; c++) begin
      apply(1'b0, 1'b0, 1'b1, 32'h10, 32'h5);
      check("t4_lat0_write_state", {30'd0, st2}, {30'd0, S_ACC});
    end
    apply(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    check("t4_lat0_read_data", ld2, 32'h5);

    for (int c = 0; c < 3; c++) apply(1'b0, 1'b0, 1'b1, 32'h300, 32'h77);
    idle();
    apply(1'b0, 1'b0, 1'b1, 32'h300, 32'hAA);
    check("t5_pre_reset_state", {30'd0, st0}, {30'd0, S_BUSY});
    apply(1'b1, 1'b0, 1'b1, 32'h300, 32'hAA);
    check("t5_reset_state", {30'd0, st0}, {30'd0, S_FREE});
    idle();
    for (int c = 0; c < 3; c++) apply(1'b0, 1'b1, 1'b0, 32'h300, 32'h0);
    check("t5_retained_data", ld0, 32'h77);

    for (int c = 0; c < 3; c++) apply(1'b0, 1'b0, 1'b1, 32'h0, 32'hCAFEF00D);
    idle();
`ifdef RAM_ERROR_CHECK_EN
    apply(1'b0, 1'b1, 1'b0, 32'h1000, 32'h0);
    check("t6_range_state", {30'd0, st0}, {30'd0, S_ERR});
    check("t6_range_load", ld0, 32'h0);
    apply(1'b0, 1'b1, 1'b1, 32'h0, 32'h55);
    check("t6_both_state", {30'd0, st0}, {30'd0, S_ERR});
`else
    for (int c = 0; c < 3; c++) apply(1'b0, 1'b1, 1'b0, 32'h1000, 32'h0);
    check("t6_wrap_data", ld0, 32'hCAFEF00D);
    idle();
    for (int c = 0; c < 3; c++) apply(1'b0, 1'b1, 1'b1, 32'h0, 32'h55);
    check("t6_both_state", {30'd0, st0}, {30'd0, S_ACC});
    check("t6_both_load", ld0, 32'h0);
    idle();
    for (int c = 0; c < 3; c++) apply(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    check("t6_both_wrote", ld0, 32'h55);
`endif

    idle();
    for (int n = 0; n < 3000; n++) begin
      logic nr, nw, nrst;
      logic [31:0] na, nd;
      nr = ren; nw = wen; na = addr; nd = data;
      r = $urandom_range(0, 15);
      if (r >= 9) begin
        case ($urandom_range(0, 3))
          0:       begin nr = 1'b0; nw = 1'b0; end
          1:       begin nr = 1'b1; nw = 1'b0; end
          2:       begin nr = 1'b0; nw = 1'b1; end
          default: begin nr = (r == 15); nw = 1'b1; end
        endcase
        na = 32'($urandom_range(0, 7)) << 2;
        if ($urandom_range(0, 9) == 0) na = na + 32'h1000;
        na = na | 32'($urandom_range(0, 3));
        nd = $urandom;
      end
      nrst = ($urandom_range(0, 63) == 0);
      apply(nrst, nr, nw, na, nd);
    end

    idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
